// File: rtl/gate_bist_controller.sv
// LFSR-driven logic BIST controller: applies pseudo-random patterns to a gate
// network and compacts its responses in a 16-bit MISR. Optional macro GATE_BIST_SETTLE_EN adds a settle cycle per pattern.
module gate_bist_controller #(
  parameter int unsigned NUM_PATTERNS = 500,
  parameter logic [23:0] LFSR_SEED    = 24'h000001,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  response,
  output logic [23:0] pattern,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] pattern_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [23:0] SEED  = (LFSR_SEED == 24'h0) ? 24'h000001 : LFSR_SEED;
  localparam logic [15:0] NUM_P = NUM_PATTERNS[15:0];

`ifdef GATE_BIST_SETTLE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_SETTLE = 2'd3} state_t;
  localparam state_t FIRST_ST = S_SETTLE;
  localparam state_t NEXT_ST  = S_SETTLE;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  localparam state_t FIRST_ST = S_RUN;
  localparam state_t NEXT_ST  = S_RUN;
`endif

  state_t      state_q, state_d;
  logic [23:0] pattern_q, pattern_d;
  logic [15:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic        fb;
  logic [23:0] lfsr_nxt;
  logic [15:0] misr_nxt;
  logic [15:0] cnt_nxt;

  always_comb begin
    fb       = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
    lfsr_nxt = {pattern_q[22:0], pattern_q[23] ^ pattern_q[22] ^ pattern_q[21] ^ pattern_q[16]};
    misr_nxt = {sig_q[14:0], fb} ^ {6'b0, response};
    cnt_nxt  = cnt_q + 16'd1;

    state_d   = state_q;
    pattern_d = pattern_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = FIRST_ST;
          pattern_d = SEED;
          sig_d     = 16'h0;
          cnt_d     = 16'h0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_RUN: begin
        // Sample edge: response reflects the pattern applied before this edge.
        pattern_d = lfsr_nxt;
        sig_d     = misr_nxt;
        cnt_d     = cnt_nxt;
        if (cnt_nxt == NUM_P) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (misr_nxt == GOLDEN_SIG);
        end else begin
          state_d = NEXT_ST;
        end
      end
`ifdef GATE_BIST_SETTLE_EN
      S_SETTLE: state_d = S_RUN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= 24'h0;
      sig_q     <= 16'h0;
      cnt_q     <= 16'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign pattern       = pattern_q;
  assign signature     = sig_q;
  assign pattern_count = cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Scoreboard bench for gate_bist_controller: three instances cover N=4/seed 0,
// N=1 with golden 03FF, and the default N=500 run with a pattern-derived response.
module tb_gate_bist_controller;

`ifdef GATE_BIST_SETTLE_EN
  localparam int F = 2;
`else
  localparam int F = 1;
`endif

  typedef struct packed {
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        pass;
    logic [23:0] pat;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a, start_b, start_c;
  logic [9:0]  resp_a, resp_b, resp_c;
  logic [23:0] pat_a, pat_b, pat_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  // Stand-in gate network for the long run.
  assign resp_c = pat_c[9:0] ^ pat_c[23:14];

  gate_bist_controller #(.NUM_PATTERNS(4), .LFSR_SEED(24'h0), .GOLDEN_SIG(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .response(resp_a), .pattern(pat_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pattern_count(cnt_a));

  gate_bist_controller #(.NUM_PATTERNS(1), .LFSR_SEED(24'h000001), .GOLDEN_SIG(16'h03FF)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .response(resp_b), .pattern(pat_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pattern_count(cnt_b));

  gate_bist_controller dut_c (
    .clk(clk), .rst(rst), .start(start_c), .response(resp_c), .pattern(pat_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .pattern_count(cnt_c));

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic [15:0] c, input logic p,
                              input logic [23:0] pt, input int cy);
    exp_t e;
    e.sig = s; e.cnt = c; e.pass = p; e.pat = pt; e.cyc = cy;
    return e;
  endfunction

  // Reference run for dut_c: seed 1, response derived from the applied pattern.
  function automatic exp_t model_c(input int n, input int cy);
    logic [23:0] p;
    logic [15:0] s;
    logic [9:0]  r;
    logic        fb;
    p = 24'h000001;
    s = 16'h0;
    for (int i = 0; i < n; i++) begin
      r  = p[9:0] ^ p[23:14];
      fb = s[15] ^ s[14] ^ s[12] ^ s[3];
      s  = {s[14:0], fb} ^ {6'b0, r};
      p  = {p[22:0], p[23] ^ p[22] ^ p[21] ^ p[16]};
    end
    return mk(s, n[15:0], s == 16'h0, p, cy);
  endfunction

  task automatic check_done(input string nm, input exp_t e, input logic [15:0] s,
                            input logic [15:0] c, input logic ps, input logic bs,
                            input logic [23:0] pt);
    chk({nm, "_sig"}, 32'(s), 32'(e.sig));
    chk({nm, "_cnt"}, 32'(c), 32'(e.cnt));
    chk({nm, "_pass"}, 32'(ps), 32'(e.pass));
    chk({nm, "_busy"}, 32'(bs), 32'd0);
    chk({nm, "_pat"}, 32'(pt), 32'(e.pat));
    chk({nm, "_latency"}, cyc, e.cyc);
  endtask

  task automatic unexp(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s_unexpected_done: got done=1 expected no pending run", nm);
  endtask

  initial begin
    logic pa;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a && !pa) begin
        if (qa.size() == 0) unexp("a");
        else check_done("a", qa.pop_front(), sig_a, cnt_a, pass_a, busy_a, pat_a);
      end
      pa = done_a;
    end
  end

  initial begin
    logic pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (done_b && !pb) begin
        if (qb.size() == 0) unexp("b");
        else check_done("b", qb.pop_front(), sig_b, cnt_b, pass_b, busy_b, pat_b);
      end
      pb = done_b;
    end
  end

  initial begin
    logic pc;
    pc = 1'b0;
    forever begin
      @(negedge clk);
      if (done_c && !pc) begin
        if (qc.size() == 0) unexp("c");
        else check_done("c", qc.pop_front(), sig_c, cnt_c, pass_c, busy_c, pat_c);
      end
      pc = done_c;
    end
  end

  function automatic logic dn(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input int w, input int budget);
    int k;
    k = 0;
    while (!dn(w) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_in_time"}, 32'(dn(w)), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    resp_a = 10'h0; resp_b = 10'h0;
    tick(2);
    chk("rst_pat_a", 32'(pat_a), 32'h0);
    chk("rst_sig_a", 32'(sig_a), 32'h0);
    chk("rst_cnt_a", 32'(cnt_a), 32'h0);
    chk("rst_flags_a", {29'h0, busy_a, done_a, pass_a}, 32'h0);
    chk("rst_flags_c", {29'h0, busy_c, done_c, pass_c}, 32'h0);
    rst = 1'b0;
    tick(1);

    // N=4, seed 0 -> seed 1, zero response: signature 0, pass.
    qa.push_back(mk(16'h0000, 16'd4, 1'b1, 24'h000010, cyc + 1 + F * 4));
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("a_first_pat", 32'(pat_a), 32'h000001);
    chk("a_busy", 32'(busy_a), 32'd1);
    wait_done("a1", 0, F * 4 + 5);
    tick(3);
    chk("a_done_hold", 32'(done_a), 32'd1);
    chk("a_cnt_hold", 32'(cnt_a), 32'd4);
    chk("a_pat_hold", 32'(pat_a), 32'h000010);
    chk("a_pass_hold", 32'(pass_a), 32'd1);

    // Constant response 1: MISR 1,3,7,F; a mid-run start must be ignored.
    resp_a = 10'h001;
    qa.push_back(mk(16'h000F, 16'd4, 1'b0, 24'h000010, cyc + 1 + F * 4));
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("a_restart_pass_clr", 32'(pass_a), 32'd0);
    chk("a_restart_done_clr", 32'(done_a), 32'd0);
    chk("a_restart_cnt_clr", 32'(cnt_a), 32'd0);
    tick(1);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_done("a2", 0, F * 4 + 5);

    // N=1, all-ones response matches golden 03FF.
    resp_b = 10'h3FF;
    qb.push_back(mk(16'h03FF, 16'd1, 1'b1, 24'h000002, cyc + 1 + F));
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done("b1", 1, F + 5);
    tick(1);

    // N=1, zero response misses the golden signature.
    resp_b = 10'h000;
    qb.push_back(mk(16'h0000, 16'd1, 1'b0, 24'h000002, cyc + 1 + F));
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done("b2", 1, F + 5);

    // Default run: LFSR walk, then reset around cycle 100.
    start_c = 1'b1;
    tick(1);
    start_c = 1'b0;
    chk("c_pat0", 32'(pat_c), 32'h000001);
    tick(F);
    chk("c_pat1", 32'(pat_c), 32'h000002);
    tick(F);
    chk("c_pat2", 32'(pat_c), 32'h000004);
    tick(100 - 2 * F - 1);
    rst = 1'b1;
    tick(1);
    chk("c_abort_pat", 32'(pat_c), 32'h0);
    chk("c_abort_sig", 32'(sig_c), 32'h0);
    chk("c_abort_cnt", 32'(cnt_c), 32'h0);
    chk("c_abort_flags", {29'h0, busy_c, done_c, pass_c}, 32'h0);
    rst = 1'b0;
    tick(3);
    chk("c_idle_after_rst", 32'(busy_c), 32'd0);

    qc.push_back(model_c(500, cyc + 1 + F * 500));
    start_c = 1'b1;
    tick(1);
    start_c = 1'b0;
    wait_done("c1", 2, F * 500 + 10);
    tick(2);

    // start held high for the whole run: one run, count 500.
    qc.push_back(model_c(500, cyc + 1 + F * 500));
    start_c = 1'b1;
    tick(1);
    wait_done("c2", 2, F * 500 + 10);
    start_c = 1'b0;
    tick(3);
    chk("c_held_done", 32'(done_c), 32'd1);
    chk("c_held_cnt", 32'(cnt_c), 32'd500);

    tick(2);
    chk("sb_a_drained", qa.size(), 32'd0);
    chk("sb_b_drained", qb.size(), 32'd0);
    chk("sb_c_drained", qc.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/gate_bist_controller.md
GATE_BIST_CONTROLLER -- requirements
Module: gate_bist_controller

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 500: number of patterns applied per run, legal range 1..65535.
REQ-002 SHALL have parameter LFSR_SEED, default 24'h000001: initial pattern value.
REQ-003 SHALL have parameter GOLDEN_SIG, default 16'h0000: expected final signature.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled at a rising edge.
REQ-007 SHALL have port response, input, 10 bits: combinational outputs of the gate network under test.
REQ-008 SHALL have port pattern, output, 24 bits: stimulus driven to the 24 network inputs, registered.
REQ-009 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-010 SHALL have port done, output, 1 bit: run complete; held until the next start or rst.
REQ-011 SHALL have port pass, output, 1 bit: signature equals GOLDEN_SIG; valid only while done=1, otherwise 0.
REQ-012 SHALL have port signature, output, 16 bits: current MISR value.
REQ-013 SHALL have port pattern_count, output, 16 bits: number of responses compacted in the current run.

Function
REQ-014 SHALL implement states IDLE, RUN, SETTLE (REQ-030 only) and DONE.
REQ-015 In IDLE or DONE with start=1, the block SHALL on that edge:
  - load pattern with LFSR_SEED, or 24'h000001 if LFSR_SEED is 0;
  - clear signature and pattern_count;
  - set busy=1, done=0, pass=0;
  - enter RUN.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 Each sample edge SHALL update the LFSR as pattern <= {pattern[22:0], pattern[23]^pattern[22]^pattern[21]^pattern[16]}.
REQ-018 Each sample edge SHALL update the MISR as signature <= {signature[14:0], fb} ^ {6'b0, response}, where fb = signature[15]^signature[14]^signature[12]^signature[3].
REQ-019 Each sample edge SHALL increment pattern_count by 1.
REQ-020 Without REQ-030, every edge in RUN SHALL be a sample edge.
REQ-021 The sample edge on which pattern_count reaches NUM_PATTERNS SHALL:
  - enter DONE;
  - set busy=0 and done=1;
  - set pass=1 if the updated signature equals GOLDEN_SIG, else 0.
REQ-022 In DONE, pattern, signature and pattern_count SHALL hold.
REQ-023 Run latency SHALL be NUM_PATTERNS cycles from the start edge to the done edge; NUM_PATTERNS=1 SHALL give done on the edge after start.

Reset
REQ-024 When rst=1 at an edge, the block SHALL enter IDLE with pattern=24'h000000, signature=0, pattern_count=0, busy=0, done=0, pass=0.
REQ-025 rst SHALL take priority over start and SHALL abort a run mid-operation, discarding partial signature and count.
REQ-026 After rst, the next run SHALL begin only on a subsequent start edge.

Configuration
REQ-027 Macro GATE_BIST_SETTLE_EN SHALL select the settle-cycle feature.
REQ-028 Without GATE_BIST_SETTLE_EN, RUN SHALL apply and sample one pattern per cycle, and the SETTLE state SHALL not exist.
REQ-029 With GATE_BIST_SETTLE_EN, the start edge SHALL enter SETTLE instead of RUN.
REQ-030 With GATE_BIST_SETTLE_EN, the block SHALL alternate SETTLE -> RUN; only RUN edges are sample edges, and a non-final sample edge SHALL return to SETTLE.
REQ-031 With GATE_BIST_SETTLE_EN, run latency SHALL be 2*NUM_PATTERNS cycles.

Verification
REQ-032 Scenario: default seed, start pulse -> pattern=24'h000001 after the start edge, then 24'h000002 and 24'h000004 on the next two edges.
REQ-033 Scenario: NUM_PATTERNS=1, response=10'h3FF, GOLDEN_SIG=16'h03FF -> one edge after start, signature=16'h03FF, pattern_count=1, done=1, pass=1, busy=0.
REQ-034 Scenario: NUM_PATTERNS=4, response=0, LFSR_SEED=0 -> first pattern=24'h000001; done after exactly 4 cycles (8 with GATE_BIST_SETTLE_EN); signature=0; pass=1.
REQ-035 Scenario: start held high throughout a NUM_PATTERNS=500 run -> single run; done at cycle 500; pattern_count=500.
REQ-036 Scenario: rst asserted at cycle 100 of a run -> all outputs 0 next cycle; a new start yields the same signature as an uninterrupted run.
REQ-037 Scenario: GOLDEN_SIG=16'h0001 with response=0 -> done=1, pass=0.
